if_fetch: RTL and testbench

Instruction-fetch controller sitting directly downstream of the PC register and upstream of the IF/ID boundary. Takes the current fetch address and its fetch-exception word, issues one SRAM-like read on the instruction bus, and tells the PC register when to advance. Delivers registered {valid, pc, inst, excep} to decode. Handles flushes from exceptions and branches by cancelling in-flight reads, and holds returned data in a one-entry buffer while decode is stalled.

---
 rtl/if_fetch_pkg.sv | 27 ++
 rtl/if_fetch_if.sv | 28 ++
 rtl/if_hold_buf.sv | 37 +++
 rtl/if_fetch.sv | 184 ++++++++++++++++++
 tb/tb_if_fetch.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants, state encodings and types for the fetch stage
package if_fetch_pkg;

  // Reset is asserted when rst equals this level.
  localparam logic        RST_ENABLE     = 1'b0;
  localparam logic [31:0] ZEROWORD32     = 32'h0000_0000;
  // Exception word reported for an instruction-bus error.
  localparam logic [31:0] EXCEP_TYPE_BUS = 32'h4000_0000;

  // Fetch FSM encodings.
  localparam logic [2:0] IF_IDLE   = 3'd0;
  localparam logic [2:0] IF_REQ    = 3'd1;
  localparam logic [2:0] IF_DATA   = 3'd2;
  localparam logic [2:0] IF_CANCEL = 3'd3;
  localparam logic [2:0] IF_HOLD   = 3'd4;

  // One fetched instruction together with its address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic excep_pending(input logic [31:0] excep);
    return excep != ZEROWORD32;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// rtl/if_fetch_if.sv - SRAM-like instruction read bus between fetch and memory
//
// inst_req/inst_addr      : request and address from the fetch stage
// inst_addr_ok            : slave accepted the address
// inst_data_ok/inst_rdata : read data returned
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - one-entry {pc, inst} buffer used while decode is stalled
//
// clk, rst  : clock, synchronous active-low reset
// i_load    : capture i_entry and mark full
// i_clear   : drop the entry (wins over i_load)
// i_entry   : {pc, inst} to capture
// o_full    : buffer holds a valid entry
// o_entry   : stored {pc, inst}
import if_fetch_pkg::*;

module if_hold_buf (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         r_full;
  fetch_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || i_clear) begin
      r_full  <= 1'b0;
      r_entry <= '0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_entry <= i_entry;
    end
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch controller between PC register and IF/ID
//
// clk, rst         : clock, synchronous active-low reset
// pc_i, pc_excep_i : fetch address and its fetch-exception word
// stall_i          : decode not accepting this cycle
// flush_i          : redirect, kills in-flight fetch work
// bus              : instruction read bus (master side)
// inst_stall_o     : hold PC; low only in the cycle an instruction/bubble is handed over
// id_*_o           : registered decode outputs
import if_fetch_pkg::*;

module if_fetch (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       pc_excep_i,
  input  logic              stall_i,
  input  logic              flush_i,
  if_fetch_if.master        bus,
  output logic              inst_stall_o,
  output logic              id_valid_o,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic [31:0]       id_excep_o
);

  logic [2:0]   r_state;
  logic [31:0]  r_addr;
  logic         r_cancel_pending;

  logic [2:0]   w_state_next;
  logic         w_in_reset;
  logic         w_fetch_ok;
  logic         w_req;
  logic         w_latch_addr;
  logic         w_cancel_set;
  logic         w_cancel_clr;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_buf_full;
  logic         w_handover;
  fetch_entry_t w_hand_entry;
  logic [31:0]  w_hand_excep;
  fetch_entry_t w_buf_in;
  fetch_entry_t w_buf_out;

  assign w_in_reset = (rst == RST_ENABLE);
  assign w_fetch_ok = !excep_pending(pc_excep_i);

  // In IDLE the address comes straight from the PC so a zero-wait slave can
  // accept it in the same cycle; REQ replays the latched copy.
  assign w_req = !w_in_reset &&
                 ((r_state == IF_IDLE && !flush_i && w_fetch_ok) || r_state == IF_REQ);
  assign bus.inst_req  = w_req;
  assign bus.inst_addr = !w_req ? ZEROWORD32 :
                         (r_state == IF_IDLE) ? pc_i : r_addr;

  assign w_buf_in.pc   = r_addr;
  assign w_buf_in.inst = bus.inst_rdata;

  always_comb begin
    w_state_next = r_state;
    w_latch_addr = 1'b0;
    w_cancel_set = 1'b0;
    w_cancel_clr = 1'b0;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    w_handover   = 1'b0;
    w_hand_entry = '0;
    w_hand_excep = ZEROWORD32;
    case (r_state)
      IF_IDLE: begin
        if (!flush_i) begin
          if (w_fetch_ok) begin
            w_latch_addr = 1'b1;
            w_state_next = bus.inst_addr_ok ? IF_DATA : IF_REQ;
          end else if (!stall_i) begin
            // Faulting fetch: no bus access, pass a bubble carrying the exception.
            w_handover        = 1'b1;
            w_hand_entry.pc   = pc_i;
            w_hand_entry.inst = ZEROWORD32;
            w_hand_excep      = pc_excep_i;
          end
        end
      end
      IF_REQ: begin
        if (bus.inst_addr_ok) begin
          w_cancel_clr = 1'b1;
          // The read is now owned by the slave, so a flush can only discard its data.
          w_state_next = (r_cancel_pending || flush_i) ? IF_CANCEL : IF_DATA;
        end else if (flush_i) begin
          w_cancel_set = 1'b1;
        end
      end
      IF_DATA: begin
        if (bus.inst_data_ok) begin
          if (flush_i) begin
            w_state_next = IF_IDLE;
          end else if (stall_i) begin
            w_buf_load   = 1'b1;
            w_state_next = IF_HOLD;
          end else begin
            w_handover        = 1'b1;
            w_hand_entry.pc   = r_addr;
            w_hand_entry.inst = bus.inst_rdata;
            w_state_next      = IF_IDLE;
          end
        end else if (flush_i) begin
          w_state_next = IF_CANCEL;
        end
      end
      IF_CANCEL: begin
        if (bus.inst_data_ok) begin
          w_state_next = IF_IDLE;
        end
      end
      IF_HOLD: begin
        // An empty buffer here would be unreachable; recover to IDLE if it happens.
        if (flush_i || !w_buf_full) begin
          w_buf_clear  = 1'b1;
          w_state_next = IF_IDLE;
        end else if (!stall_i) begin
          w_handover   = 1'b1;
          w_hand_entry = w_buf_out;
          w_buf_clear  = 1'b1;
          w_state_next = IF_IDLE;
        end
      end
      default: begin
        w_state_next = IF_IDLE;
      end
    endcase
  end

  assign inst_stall_o = w_in_reset || !w_handover;

  always_ff @(posedge clk) begin
    if (w_in_reset) begin
      r_state          <= IF_IDLE;
      r_addr           <= ZEROWORD32;
      r_cancel_pending <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_latch_addr) begin
        r_addr <= pc_i;
      end
      if (w_cancel_clr) begin
        r_cancel_pending <= 1'b0;
      end else if (w_cancel_set) begin
        r_cancel_pending <= 1'b1;
      end
    end
  end

  // ID regs: flush only kills valid; pc/inst/excep keep their last contents.
  always_ff @(posedge clk) begin
    if (w_in_reset) begin
      id_valid_o <= 1'b0;
      id_pc_o    <= ZEROWORD32;
      id_inst_o  <= ZEROWORD32;
      id_excep_o <= ZEROWORD32;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
    end else if (w_handover) begin
      id_valid_o <= 1'b1;
      id_pc_o    <= w_hand_entry.pc;
      id_inst_o  <= w_hand_entry.inst;
      id_excep_o <= w_hand_excep;
    end else if (!stall_i) begin
      id_valid_o <= 1'b0;
    end
  end

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_entry (w_buf_in),
    .o_full  (w_buf_full),
    .o_entry (w_buf_out)
  );

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed cycle-table bench for if_fetch
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic [31:0] pc_excep_i;
  logic        stall_i;
  logic        flush_i;
  logic        inst_stall_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_excep_o;

  if_fetch_if bus ();

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_excep_i   (pc_excep_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .bus          (bus),
    .inst_stall_o (inst_stall_o),
    .id_valid_o   (id_valid_o),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o),
    .id_excep_o   (id_excep_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] ex;
    logic        st;
    logic        fl;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        stl;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] iin;
    logic [31:0] iex;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;
  int   pulses;

  function automatic void add(input logic r, input logic [31:0] pc, input logic [31:0] ex,
                              input logic st, input logic fl, input logic aok, input logic dok,
                              input logic [31:0] rd, input logic req, input logic [31:0] addr,
                              input logic stl, input logic v, input logic [31:0] ipc,
                              input logic [31:0] iin, input logic [31:0] iex);
    vec_t t;
    t.rst = r;  t.pc = pc;  t.ex = ex;  t.st = st;  t.fl = fl;
    t.aok = aok; t.dok = dok; t.rd = rd;
    t.req = req; t.addr = addr; t.stl = stl; t.v = v;
    t.ipc = ipc; t.iin = iin; t.iex = iex;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %08h expected %08h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and settle before sampling.
  task automatic drive(input logic r, input logic [31:0] pc, input logic [31:0] ex,
                       input logic st, input logic fl, input logic aok, input logic dok,
                       input logic [31:0] rd);
    @(negedge clk);
    rst = r; pc_i = pc; pc_excep_i = ex; stall_i = st; flush_i = fl;
    bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
    #1;
  endtask

  task automatic chk_all(input int row, input logic req, input logic [31:0] addr,
                         input logic stl, input logic v, input logic [31:0] ipc,
                         input logic [31:0] iin, input logic [31:0] iex);
    chk("inst_req",     row, {31'd0, bus.inst_req}, {31'd0, req});
    chk("inst_addr",    row, bus.inst_addr,         addr);
    chk("inst_stall_o", row, {31'd0, inst_stall_o}, {31'd0, stl});
    chk("id_valid_o",   row, {31'd0, id_valid_o},   {31'd0, v});
    chk("id_pc_o",      row, id_pc_o,               ipc);
    chk("id_inst_o",    row, id_inst_o,             iin);
    chk("id_excep_o",   row, id_excep_o,            iex);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; pc_i = '0; pc_excep_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    repeat (2) @(negedge clk);

    //   rst pc            ex            st fl ak dk rdata          req addr          stl v  id_pc         id_inst       id_excep
    // reset, then zero-wait fetch of 0xbfc00000
    add(0, 32'hbfc00000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        32'h0);
    add(1, 32'hbfc00000, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00000, 1, 0, 32'h0,        32'h0,        32'h0);
    add(1, 32'hbfc00000, 32'h0,        0, 0, 0, 1, 32'h24080001, 0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0);
    // next fetch waits one cycle for addr_ok, then decode stalls from data_ok for 4 cycles
    add(1, 32'hbfc00004, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'hbfc00004, 1, 1, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'hbfc00004, 1, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00004, 1, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        1, 0, 0, 1, 32'h8c090010, 0, 32'h0,        1, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    add(1, 32'hbfc00004, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'hbfc00000, 32'h24080001, 32'h0);
    // buffered inst appears; flush in DATA sends the late 0xdeadbeef to CANCEL
    add(1, 32'hbfc00008, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00008, 1, 1, 32'hbfc00004, 32'h8c090010, 32'h0);
    add(1, 32'hbfc00008, 32'h0,        0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'hbfc00004, 32'h8c090010, 32'h0);
    add(1, 32'hbfc00100, 32'h0,        0, 0, 0, 1, 32'hdeadbeef, 0, 32'h0,        1, 0, 32'hbfc00004, 32'h8c090010, 32'h0);
    // new pc; flush coinciding with data_ok drops the data
    add(1, 32'hbfc00100, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00100, 1, 0, 32'hbfc00004, 32'h8c090010, 32'h0);
    add(1, 32'hbfc00100, 32'h0,        0, 1, 0, 1, 32'h3c1d8000, 0, 32'h0,        1, 0, 32'hbfc00004, 32'h8c090010, 32'h0);
    // flush with addr_ok in IDLE: no request
    add(1, 32'hbfc00200, 32'h0,        0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'hbfc00004, 32'h8c090010, 32'h0);
    // misaligned pc -> bubble
    add(1, 32'hbfc00002, 32'h80000000, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'hbfc00004, 32'h8c090010, 32'h0);
    // flush while waiting in REQ: cancel_pending, late addr_ok goes to CANCEL
    add(1, 32'hbfc00010, 32'h0,        1, 0, 0, 0, 32'h0,        1, 32'hbfc00010, 1, 1, 32'hbfc00002, 32'h0,        32'h80000000);
    add(1, 32'hbfc00010, 32'h0,        1, 1, 0, 0, 32'h0,        1, 32'hbfc00010, 1, 1, 32'hbfc00002, 32'h0,        32'h80000000);
    add(1, 32'hbfc00020, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00010, 1, 0, 32'hbfc00002, 32'h0,        32'h80000000);
    add(1, 32'hbfc00020, 32'h0,        0, 0, 0, 1, 32'h11111111, 0, 32'h0,        1, 0, 32'hbfc00002, 32'h0,        32'h80000000);
    add(1, 32'hbfc00020, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00020, 1, 0, 32'hbfc00002, 32'h0,        32'h80000000);
    add(1, 32'hbfc00020, 32'h0,        0, 0, 0, 1, 32'h22222222, 0, 32'h0,        0, 0, 32'hbfc00002, 32'h0,        32'h80000000);
    // reset while in DATA
    add(1, 32'hbfc00024, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'hbfc00024, 1, 1, 32'hbfc00020, 32'h22222222, 32'h0);
    add(0, 32'hbfc00024, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'hbfc00020, 32'h22222222, 32'h0);
    add(1, 32'hbfc00024, 32'h0,        0, 0, 0, 0, 32'h0,        1, 32'hbfc00024, 1, 0, 32'h0,        32'h0,        32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].ex, vecs[i].st, vecs[i].fl,
            vecs[i].aok, vecs[i].dok, vecs[i].rd);
      chk_all(i, vecs[i].req, vecs[i].addr, vecs[i].stl, vecs[i].v,
              vecs[i].ipc, vecs[i].iin, vecs[i].iex);
    end

    // Wait states: REQ on 0xbfc00024 holds request/address while pc_i wanders.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'hbfc00100 + 32'(k * 4), 32'h0, 0, 0, 0, 0, 32'h0);
      chk("ws_req",  100 + k, {31'd0, bus.inst_req}, 32'd1);
      chk("ws_addr", 100 + k, bus.inst_addr,         32'hbfc00024);
    end
    drive(1, 32'hbfc00100, 32'h0, 0, 0, 1, 0, 32'h0);
    chk("ws_addr_ok", 103, bus.inst_addr, 32'hbfc00024);
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'hbfc00100, 32'h0, 0, 0, 0, 0, 32'h0);
      chk("ws_data_req", 104 + k, {31'd0, bus.inst_req}, 32'd0);
      chk("ws_data_stl", 104 + k, {31'd0, inst_stall_o}, 32'd1);
    end
    drive(1, 32'hbfc00100, 32'h0, 0, 0, 0, 1, 32'h33333333);
    chk("ws_handover_stl", 106, {31'd0, inst_stall_o}, 32'd0);

    // Flush keeps IDLE quiet; exactly one valid pulse must come out.
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'hbfc00028, 32'h0, 0, 1, 0, 0, 32'h0);
      if (id_valid_o) pulses++;
      if (k == 0) begin
        chk("ws_id_pc",   107, id_pc_o,   32'hbfc00024);
        chk("ws_id_inst", 107, id_inst_o, 32'h33333333);
      end
      chk("ws_flush_req", 107 + k, {31'd0, bus.inst_req}, 32'd0);
    end
    chk("ws_valid_pulses", 111, 32'(pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
